// File: rtl/destination_pkg.sv
// destination_pkg: shared definitions for the destination monitor.
//   - next_state output codes
//   - FSM state encoding (also driven out on o_fsm_state for debug)
//   - sensor vector bit positions
package destination_pkg;

    localparam logic [1:0] NS_STAY    = 2'b00;
    localparam logic [1:0] NS_ADVANCE = 2'b01;
    localparam logic [1:0] NS_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLIMB   = 3'd1,
        ST_QUALIFY = 3'd2,
        ST_ARRIVED = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    localparam int SENS_LIFE = 0;
    localparam int SENS_OXY  = 1;
    localparam int SENS_RAD  = 2;
    localparam int SENS_TEMP = 3;

endpackage

// File: rtl/persistence_counter.sv
// persistence_counter: saturating up-counter for "N consecutive events" checks.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_clr    clear to 0 (wins over i_inc)
//   i_inc    increment, saturating at MAX
//   o_count  current count
//   o_hit    high when this edge's increment brings the count to MAX
module persistence_counter #(
    parameter  int MAX = 4,
    localparam int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_hit
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] LAST_V = W'(MAX - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && r_count != MAX_V)
            r_count <= r_count + 1'b1;
    end

    // Look-ahead so the FSM can change state on the same edge the
    // threshold is reached.
    assign o_hit   = i_inc && !i_clr && (r_count == LAST_V);
    assign o_count = r_count;

endmodule

// File: rtl/destination_monitor.sv
// destination_monitor: decides when the destination has been reached.
// Samples altitude and a sensor vector on i_sample_valid, requires the
// destination condition for HOLD_CNT consecutive qualifying samples (with
// altitude hysteresis) and aborts after FAULT_CNT consecutive unhealthy ones.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_start            begin monitoring (IDLE only)
//   i_sample_valid     i_altitude / i_sens valid this cycle
//   i_altitude         unsigned altitude
//   i_sens             sensor vector
//   i_ack              sequencer accepts o_next_state (ARRIVED/ABORT only)
//   o_next_state       00 STAY, 01 ADVANCE, 11 ABORT (registered, held)
//   o_busy             high in CLIMB/QUALIFY
//   o_fsm_state        current FSM state (debug)
//   o_hold_level       current qualify count
module destination_monitor
    import destination_pkg::*;
#(
    parameter int                ALT_W     = 10,
    parameter logic [ALT_W-1:0]  ALT_TGT   = 10'b1100000000,
    parameter int                ALT_HYST  = 16,
    parameter int                N_SENS    = 4,
    parameter logic [N_SENS-1:0] OK_PAT    = 4'b1011,
    parameter logic [N_SENS-1:0] OK_MASK   = 4'b1111,
    parameter int                HOLD_CNT  = 4,
    parameter int                FAULT_CNT = 3,
    localparam int               HW        = $clog2(HOLD_CNT + 1),
    localparam int               FW        = $clog2(FAULT_CNT + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_sample_valid,
    input  logic [ALT_W-1:0]  i_altitude,
    input  logic [N_SENS-1:0] i_sens,
    input  logic              i_ack,
    output logic [1:0]        o_next_state,
    output logic              o_busy,
    output logic [2:0]        o_fsm_state,
    output logic [HW-1:0]     o_hold_level
);

    // Fallback floor, saturated at zero when the hysteresis exceeds the target.
    localparam int               FLOOR_I   = (int'(ALT_TGT) > ALT_HYST) ? int'(ALT_TGT) - ALT_HYST : 0;
    localparam logic [ALT_W-1:0] ALT_FLOOR = ALT_W'(FLOOR_I);
    localparam logic [FW-1:0]    FAULT_V   = FW'(FAULT_CNT);

    state_t        r_state;
    logic [1:0]    r_next_state;
    logic          r_busy;

    logic          w_healthy, w_reached, w_fallen;
    logic          w_monitoring, w_smp, w_start_acc, w_ack_acc;
    logic          w_hold_inc, w_hold_clr, w_hold_hit;
    logic          w_fault_inc, w_fault_clr, w_fault_hit, w_abort;
    logic [HW-1:0] w_hold_cnt;
    logic [FW-1:0] w_fault_cnt;

    assign w_healthy    = ((i_sens ^ OK_PAT) & OK_MASK) == '0;
    assign w_reached    = i_altitude >= ALT_TGT;
    assign w_fallen     = i_altitude <  ALT_FLOOR;

    assign w_monitoring = (r_state == ST_CLIMB) || (r_state == ST_QUALIFY);
    assign w_smp        = w_monitoring && i_sample_valid;
    assign w_start_acc  = (r_state == ST_IDLE) && i_start;
    assign w_ack_acc    = ((r_state == ST_ARRIVED) || (r_state == ST_ABORT)) && i_ack;

    // Fault counter tracks consecutive unhealthy samples: any healthy one clears it.
    assign w_fault_inc  = w_smp && !w_healthy;
    assign w_fault_clr  = w_start_acc || w_ack_acc || (w_smp && w_healthy);

    // Hold count only grows on healthy+reached; a fall below the floor in
    // QUALIFY restarts the climb from zero.
    assign w_hold_inc   = w_smp && w_healthy && w_reached;
    assign w_hold_clr   = w_start_acc || w_ack_acc ||
                          (w_smp && (r_state == ST_QUALIFY) && w_fallen);

    // Saturated-count term is defensive: the FSM leaves on the hit edge.
    assign w_abort      = w_fault_hit || (w_fault_cnt == FAULT_V);

    persistence_counter #(.MAX(HOLD_CNT)) u_hold (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_hold_clr),
        .i_inc   (w_hold_inc),
        .o_count (w_hold_cnt),
        .o_hit   (w_hold_hit)
    );

    persistence_counter #(.MAX(FAULT_CNT)) u_fault (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_fault_clr),
        .i_inc   (w_fault_inc),
        .o_count (w_fault_cnt),
        .o_hit   (w_fault_hit)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_next_state <= NS_STAY;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_CLIMB;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLIMB, ST_QUALIFY: begin
                    if (i_sample_valid) begin
                        // Priority: abort > arrival > climb/fallback.
                        if (w_abort) begin
                            r_state      <= ST_ABORT;
                            r_next_state <= NS_ABORT;
                            r_busy       <= 1'b0;
                        end else if (w_hold_hit) begin
                            r_state      <= ST_ARRIVED;
                            r_next_state <= NS_ADVANCE;
                            r_busy       <= 1'b0;
                        end else if (r_state == ST_CLIMB && w_hold_inc) begin
                            r_state <= ST_QUALIFY;
                        end else if (r_state == ST_QUALIFY && w_fallen) begin
                            r_state <= ST_CLIMB;
                        end
                    end
                end
                ST_ARRIVED, ST_ABORT: begin
                    if (i_ack) begin
                        r_state      <= ST_IDLE;
                        r_next_state <= NS_STAY;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_next_state <= NS_STAY;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_next_state = r_next_state;
    assign o_busy       = r_busy;
    assign o_fsm_state  = r_state;
    assign o_hold_level = w_hold_cnt;

endmodule
